// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared parameters and flush FSM state type for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 5;
  localparam int SB_DW    = 32;

  // RUN: normal operation; FLUSH: draining, stores stall;
  // DONE: single-cycle flush_done; HOLD: wait for flush_req to drop.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } sb_state_e;

endpackage

// File: rtl/store_buffer_fwd_match.sv
// rtl/store_buffer_fwd_match.sv - newest-first address match over buffered stores
// Ports:
//   addr_tbl, data_tbl : entry storage (indexed by physical slot)
//   head, count        : oldest slot and number of valid entries
//   lookup_addr        : load address
//   hit, hit_data      : newest matching entry found / its data
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0][AW-1:0]  addr_tbl,
  input  logic [DEPTH-1:0][DW-1:0]  data_tbl,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [$clog2(DEPTH):0]    count,
  input  logic [AW-1:0]             lookup_addr,
  output logic                      hit,
  output logic [DW-1:0]             hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk from oldest to newest; a later (newer) match overwrites an
  // earlier one, so the result is the newest matching entry.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr_tbl[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_tbl[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load forwarding and flush handshake
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cpu_we, cpu_re, cpu_addr,
//   cpu_wdata, cpu_rdata, cpu_stall : CPU load/store interface
//   flush_req, flush_done           : drain request level / completion pulse
//   mem_we, mem_addr, mem_wdata,
//   mem_rdata                       : data memory port
//   count                           : current occupancy
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] addr_tbl;
  logic [DEPTH-1:0][DW-1:0] data_tbl;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count_next;
  sb_state_e                state;
  sb_state_e                state_next;

  logic          is_load;
  logic          accept;
  logic          drain;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign is_load   = cpu_re && !cpu_we;
  assign cpu_stall = cpu_we && ((count == CW'(DEPTH)) || (state != RUN));
  assign accept    = cpu_we && !cpu_stall;
  // Gated by rst so that entries discarded by a reset never reach memory
  // on the reset edge.
  assign drain     = !rst && (count != '0) && !is_load;

  assign mem_we    = drain;
  assign mem_addr  = drain ? addr_tbl[head] : cpu_addr;
  assign mem_wdata = drain ? data_tbl[head] : '0;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .addr_tbl    (addr_tbl),
    .data_tbl    (data_tbl),
    .head        (head),
    .count       (count),
    .lookup_addr (cpu_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // A combined store+load request is a store; it returns zero.
  always_comb begin
    cpu_rdata = '0;
    if (!cpu_we) begin
      cpu_rdata = hit ? hit_data : mem_rdata;
    end
  end

  always_comb begin
    count_next = count;
    case ({accept, drain})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FLUSH looks at next-cycle occupancy so the last drain edge itself
  // moves the FSM to DONE.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = FLUSH;
      FLUSH:   if (count_next == '0) state_next = DONE;
      DONE:    state_next = flush_req ? HOLD : RUN;
      HOLD:    if (!flush_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      if (drain)  head <= head + PW'(1);
      if (accept) tail <= tail + PW'(1);
      count      <= count_next;
      state      <= state_next;
      flush_done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_tbl[tail] <= cpu_addr;
      data_tbl[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized self-checking bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int MW    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_we, cpu_re, flush_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall, flush_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .count      (count)
  );

  // Data memory attached to the DUT
  logic [DW-1:0] dmem [MW];
  logic          mem_ready = 1'b0;
  assign mem_rdata = dmem[mem_addr];

  function automatic logic [DW-1:0] preload_word(input int i);
    return 32'h10001008 + 32'(i) * 32'h00010001;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MW; i++) dmem[i] <= preload_word(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: queue of pending stores, expected memory, flush mode
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sbq[$];
  logic [DW-1:0] rmem [MW];
  int            mode;  // 0 normal, 1 flushing, 2 done pulse, 3 hold
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic fr, input logic r);
    logic          ld, stl, drn;
    logic [DW-1:0] exp_rd;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; flush_req = fr; rst = r;
    @(negedge clk);
    ld  = re && !we;
    stl = we && (sbq.size() == DEPTH || mode != 0);
    drn = !r && sbq.size() != 0 && !ld;
    check("stall", cpu_stall, stl);
    check("mem_we", mem_we, drn);
    if (drn) begin
      check("mem_addr_drain", mem_addr, sbq[0].a);
      check("mem_wdata", mem_wdata, sbq[0].d);
    end else begin
      check("mem_addr_pass", mem_addr, a);
    end
    check("count", count, sbq.size());
    check("flush_done", flush_done, mode == 2);
    if (re) begin
      if (we) exp_rd = '0;
      else begin
        exp_rd = rmem[a];
        foreach (sbq[i]) if (sbq[i].a == a) exp_rd = sbq[i].d;
      end
      check("rdata", cpu_rdata, exp_rd);
    end
    if (r) begin
      sbq.delete();
      mode = 0;
    end else begin
      if (drn) begin
        rmem[sbq[0].a] = sbq[0].d;
        void'(sbq.pop_front());
      end
      if (we && !stl) sbq.push_back('{a: a, d: d});
      case (mode)
        0: if (fr) mode = 1;
        1: if (sbq.size() == 0) mode = 2;
        2: mode = fr ? 3 : 0;
        default: if (!fr) mode = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic fr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, AW'(0), '0, fr, 1'b0);
  endtask

  initial begin
    logic fr;
    cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0; flush_req = 0; rst = 1;
    for (int i = 0; i < MW; i++) rmem[i] = preload_word(i);
    mode = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // load of preloaded word with empty buffer
    step(0, 1, 0, 0, 0, 0);
    check("preload_word0", rmem[0], 32'h10001008);

    // forward a pending store, then let it drain and read memory
    step(1, 0, 3, 32'hAAAA0001, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    check("word3_before_drain", dmem[3], preload_word(3));
    idle(1, 0);
    check("word3_after_drain", dmem[3], 32'hAAAA0001);
    step(0, 1, 3, 0, 0, 0);

    // duplicate addresses: newest wins
    step(1, 0, 5, 32'h11, 0, 0);
    step(1, 0, 5, 32'h22, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    idle(2, 0);
    check("word5_final", dmem[5], 32'h22);

    // stores interleaved with loads holding the port
    for (int i = 0; i < 5; i++) begin
      step(1, 0, AW'(8 + i), 32'hB000_0000 + 32'(i), 0, 0);
      step(0, 1, AW'(8 + i), 0, 0, 0);
    end
    step(1, 1, 9, 32'hCAFE, 0, 0);

    // flush with entries pending, stores attempted, then hold and release
    step(1, 0, 12, 32'hF1, 0, 0);
    step(1, 0, 13, 32'hF2, 1, 0);
    step(1, 0, 14, 32'hF3, 1, 0);
    step(0, 1, 13, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 15, 32'hF4, 1, 0);
    idle(2, 0);
    step(1, 0, 15, 32'hF5, 0, 0);

    // empty-buffer flush with a one-cycle request
    step(0, 0, 0, 0, 1, 0);
    idle(4, 0);

    // reset discards pending entries
    step(1, 0, 20, 32'hDEAD0001, 0, 0);
    step(1, 0, 21, 32'hDEAD0002, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3, 0);
    check("word21_discarded", dmem[21], preload_word(21));

    // randomized traffic
    fr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19) == 0) fr = ~fr;
      step(($urandom_range(2) == 0), 1'($urandom), AW'($urandom_range(7)), $urandom,
           fr, ($urandom_range(199) == 0));
    end
    idle(6, 0);

    for (int i = 0; i < MW; i++) check("mem_image", dmem[i], rmem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
